piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that drives the team's 4-bit serial-in shift-register receiver. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per bit period. Each bit is accompanied by a `shift_enable` strobe, so `serial_out`/`shift_enable` wire directly to the receiver's `serial_in`/`shift_enable`. After WIDTH strobes the receiver's `q` equals the loaded word.

---
 rtl/piso_serializer_if.sv | 33 +++
 rtl/piso_serializer.sv | 96 +++++++++
 tb/tb_piso_serializer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Parallel load handshake plus serial strobe/data pair for the PISO transmitter.
// The master side is the upstream word source and serial observer. The slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             shift_enable;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  shift_enable,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output serial_out,
        output shift_enable,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out transmitter with a per-bit strobe for a shift-register receiver.
// Each bit is held for DIV clocks. The strobe fires on the last clock of each bit period.
module piso_serializer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic                clk,
    input  logic                reset,
    piso_serializer_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             done_d;
    logic             serial_out_q;
    logic             shift_enable_q;
    logic             busy_q;
    logic             done_q;
    logic             handshake;
    logic             bit_end;

    assign bus.load_ready   = (state_q == IDLE) && !reset;
    assign handshake        = bus.load_valid && bus.load_ready;
    assign bit_end          = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);

    assign bus.serial_out   = serial_out_q;
    assign bus.shift_enable = shift_enable_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    shreg_d   = bus.data_in;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            div_cnt_q      <= '0;
            serial_out_q   <= 1'b0;
            shift_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            div_cnt_q      <= div_cnt_d;
            serial_out_q   <= (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
            shift_enable_q <= (state_d == SHIFT) && (div_cnt_d == DIV_LAST);
            busy_q         <= (state_d == SHIFT);
            done_q         <= done_d;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: three parameterisations with loopback receivers.
// Expected serial bits are queued at load time and popped whenever a strobe is observed.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(4)) if_a ();
    piso_serializer_if #(.WIDTH(4)) if_b ();
    piso_serializer_if #(.WIDTH(8)) if_c ();

    piso_serializer #(.WIDTH(4), .DIV(1)) u_a (.clk(clk), .reset(reset), .bus(if_a));
    piso_serializer #(.WIDTH(4), .DIV(3)) u_b (.clk(clk), .reset(reset), .bus(if_b));
    piso_serializer #(.WIDTH(8), .DIV(2)) u_c (.clk(clk), .reset(reset), .bus(if_c));

    logic [3:0] rx_a, rx_b;
    logic [7:0] rx_c;
    logic       exp_a[$];
    logic       exp_b[$];
    logic       exp_c[$];

    // Loopback receivers, clocked like the real shift-register receiver.
    always @(posedge clk) begin
        if (reset) begin
            rx_a <= '0;
            rx_b <= '0;
            rx_c <= '0;
        end else begin
            if (if_a.shift_enable) rx_a <= {rx_a[2:0], if_a.serial_out};
            if (if_b.shift_enable) rx_b <= {rx_b[2:0], if_b.serial_out};
            if (if_c.shift_enable) rx_c <= {rx_c[6:0], if_c.serial_out};
        end
    end

    // Scoreboard: every strobe must match the next queued bit.
    always @(negedge clk) begin
        logic eb;
        if (if_a.shift_enable === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL sb_a: got strobe with serial_out=%0b, expected no strobe", if_a.serial_out);
            end else begin
                eb = exp_a.pop_front();
                if (if_a.serial_out !== eb) begin
                    errors++;
                    $display("FAIL sb_a: serial_out=%0b expected %0b", if_a.serial_out, eb);
                end
            end
        end
        if (if_b.shift_enable === 1'b1) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL sb_b: got strobe with serial_out=%0b, expected no strobe", if_b.serial_out);
            end else begin
                eb = exp_b.pop_front();
                if (if_b.serial_out !== eb) begin
                    errors++;
                    $display("FAIL sb_b: serial_out=%0b expected %0b", if_b.serial_out, eb);
                end
            end
        end
        if (if_c.shift_enable === 1'b1) begin
            checks++;
            if (exp_c.size() == 0) begin
                errors++;
                $display("FAIL sb_c: got strobe with serial_out=%0b, expected no strobe", if_c.serial_out);
            end else begin
                eb = exp_c.pop_front();
                if (if_c.serial_out !== eb) begin
                    errors++;
                    $display("FAIL sb_c: serial_out=%0b expected %0b", if_c.serial_out, eb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({if_a.load_ready, if_b.load_ready, if_c.load_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 000", {if_a.load_ready, if_b.load_ready, if_c.load_ready});
        end
        checks++;
        if ({if_a.busy, if_a.serial_out, if_a.shift_enable, if_a.done,
             if_b.busy, if_b.serial_out, if_b.shift_enable, if_b.done,
             if_c.busy, if_c.serial_out, if_c.shift_enable, if_c.done} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {if_a.busy, if_a.serial_out, if_a.shift_enable, if_a.done,
                      if_b.busy, if_b.serial_out, if_b.shift_enable, if_b.done,
                      if_c.busy, if_c.serial_out, if_c.shift_enable, if_c.done});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({if_a.load_ready, if_b.load_ready, if_c.load_ready} !== 3'b111) begin
            errors++;
            $display("FAIL release_ready: got %b expected 111", {if_a.load_ready, if_b.load_ready, if_c.load_ready});
        end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [3:0] w = 4'b1011;
        checks++;
        if (if_a.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b expected 1", if_a.load_ready);
        end
        if_a.data_in = w;
        if_a.load_valid = 1'b1;
        for (int i = 3; i >= 0; i--) exp_a.push_back(w[i]);
        tick();
        if_a.load_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({if_a.busy, if_a.serial_out, if_a.shift_enable, if_a.done, if_a.load_ready} !== {1'b1, w[4-c], 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL basic_cycle%0d: busy/ser/se/done/rdy=%b expected %b", c,
                         {if_a.busy, if_a.serial_out, if_a.shift_enable, if_a.done, if_a.load_ready},
                         {1'b1, w[4-c], 1'b1, 1'b0, 1'b0});
            end
            tick();
        end
        checks++;
        if ({if_a.done, if_a.busy, if_a.load_ready} !== 3'b101) begin
            errors++;
            $display("FAIL basic_done: done/busy/rdy=%b expected 101", {if_a.done, if_a.busy, if_a.load_ready});
        end
        checks++;
        if (rx_a !== w) begin
            errors++;
            $display("FAIL basic_rx: q=%h expected %h", rx_a, w);
        end
        tick();
        checks++;
        if (if_a.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b expected 0", if_a.done);
        end
        $display("test_basic done word=%b rx=%b", w, rx_a);
    endtask

    task automatic test_div3();
        logic [3:0] w = 4'b0110;
        if_b.data_in = w;
        if_b.load_valid = 1'b1;
        for (int i = 3; i >= 0; i--) exp_b.push_back(w[i]);
        tick();
        if_b.load_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            logic se_exp;
            se_exp = ((c % 3) == 0);
            checks++;
            if ({if_b.busy, if_b.serial_out, if_b.shift_enable, if_b.done} !== {1'b1, w[3-(c-1)/3], se_exp, 1'b0}) begin
                errors++;
                $display("FAIL div3_cycle%0d: busy/ser/se/done=%b expected %b", c,
                         {if_b.busy, if_b.serial_out, if_b.shift_enable, if_b.done},
                         {1'b1, w[3-(c-1)/3], se_exp, 1'b0});
            end
            tick();
        end
        checks++;
        if ({if_b.done, if_b.busy, rx_b} !== {2'b10, w}) begin
            errors++;
            $display("FAIL div3_done: done/busy/q=%b expected %b", {if_b.done, if_b.busy, rx_b}, {2'b10, w});
        end
        tick();
        $display("test_div3 done word=%b rx=%b", w, rx_b);
    endtask

    task automatic test_width8();
        logic [7:0] w = 8'hC5;
        if_c.data_in = w;
        if_c.load_valid = 1'b1;
        for (int i = 7; i >= 0; i--) exp_c.push_back(w[i]);
        tick();
        if_c.load_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            logic se_exp;
            se_exp = ((c % 2) == 0);
            checks++;
            if ({if_c.busy, if_c.serial_out, if_c.shift_enable, if_c.done} !== {1'b1, w[7-(c-1)/2], se_exp, 1'b0}) begin
                errors++;
                $display("FAIL w8_cycle%0d: busy/ser/se/done=%b expected %b", c,
                         {if_c.busy, if_c.serial_out, if_c.shift_enable, if_c.done},
                         {1'b1, w[7-(c-1)/2], se_exp, 1'b0});
            end
            tick();
        end
        checks++;
        if ({if_c.done, if_c.busy, rx_c} !== {2'b10, w}) begin
            errors++;
            $display("FAIL w8_done: done/busy/q=%b expected %b", {if_c.done, if_c.busy, rx_c}, {2'b10, w});
        end
        tick();
        $display("test_width8 done word=%h rx=%h", w, rx_c);
    endtask

    task automatic test_back_to_back();
        logic [3:0] w1 = 4'hA;
        logic [3:0] w2 = 4'h5;
        if_a.data_in = w1;
        if_a.load_valid = 1'b1;
        for (int i = 3; i >= 0; i--) exp_a.push_back(w1[i]);
        tick();
        if_a.data_in = w2;
        for (int i = 3; i >= 0; i--) exp_a.push_back(w2[i]);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({if_a.busy, if_a.serial_out, if_a.shift_enable, if_a.load_ready} !== {1'b1, w1[4-c], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL b2b_first%0d: busy/ser/se/rdy=%b expected %b", c,
                         {if_a.busy, if_a.serial_out, if_a.shift_enable, if_a.load_ready}, {1'b1, w1[4-c], 1'b1, 1'b0});
            end
            tick();
        end
        checks++;
        if ({if_a.done, if_a.load_ready, if_a.shift_enable, rx_a} !== {3'b110, w1}) begin
            errors++;
            $display("FAIL b2b_gap: done/rdy/se/q=%b expected %b", {if_a.done, if_a.load_ready, if_a.shift_enable, rx_a}, {3'b110, w1});
        end
        tick();
        if_a.load_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({if_a.busy, if_a.serial_out, if_a.shift_enable} !== {1'b1, w2[4-c], 1'b1}) begin
                errors++;
                $display("FAIL b2b_second%0d: busy/ser/se=%b expected %b", c,
                         {if_a.busy, if_a.serial_out, if_a.shift_enable}, {1'b1, w2[4-c], 1'b1});
            end
            tick();
        end
        checks++;
        if ({if_a.done, rx_a} !== {1'b1, w2}) begin
            errors++;
            $display("FAIL b2b_done2: done/q=%b expected %b", {if_a.done, rx_a}, {1'b1, w2});
        end
        tick();
        $display("test_back_to_back done words=%h,%h rx=%h", w1, w2, rx_a);
    endtask

    task automatic test_load_ignored();
        logic [3:0] w1 = 4'h3;
        logic [3:0] w2 = 4'hF;
        if_a.data_in = w1;
        if_a.load_valid = 1'b1;
        for (int i = 3; i >= 0; i--) exp_a.push_back(w1[i]);
        tick();
        if_a.load_valid = 1'b0;
        tick();
        if_a.data_in = w2;
        if_a.load_valid = 1'b1;
        #1;
        for (int c = 2; c <= 4; c++) begin
            checks++;
            if ({if_a.busy, if_a.serial_out, if_a.load_ready} !== {1'b1, w1[4-c], 1'b0}) begin
                errors++;
                $display("FAIL ign_cycle%0d: busy/ser/rdy=%b expected %b", c,
                         {if_a.busy, if_a.serial_out, if_a.load_ready}, {1'b1, w1[4-c], 1'b0});
            end
            tick();
        end
        checks++;
        if ({if_a.done, if_a.load_ready, rx_a} !== {2'b11, w1}) begin
            errors++;
            $display("FAIL ign_done: done/rdy/q=%b expected %b", {if_a.done, if_a.load_ready, rx_a}, {2'b11, w1});
        end
        for (int i = 3; i >= 0; i--) exp_a.push_back(w2[i]);
        tick();
        if_a.load_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if ({if_a.done, rx_a} !== {1'b1, w2}) begin
            errors++;
            $display("FAIL ign_second: done/q=%b expected %b", {if_a.done, rx_a}, {1'b1, w2});
        end
        tick();
        $display("test_load_ignored done rx=%h", rx_a);
    endtask

    task automatic test_reset_midframe();
        logic [3:0] w1 = 4'b1001;
        logic [3:0] w2 = 4'b1110;
        if_a.data_in = w1;
        if_a.load_valid = 1'b1;
        exp_a.push_back(w1[3]);
        exp_a.push_back(w1[2]);
        tick();
        if_a.load_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (if_a.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready_in_reset: got %b expected 0", if_a.load_ready);
        end
        tick();
        reset = 1'b0;
        checks++;
        if ({if_a.busy, if_a.serial_out, if_a.shift_enable, if_a.done} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_outputs: busy/ser/se/done=%b expected 0000",
                     {if_a.busy, if_a.serial_out, if_a.shift_enable, if_a.done});
        end
        #1;
        checks++;
        if (if_a.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_release_ready: got %b expected 1", if_a.load_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({if_a.busy, if_a.shift_enable, if_a.done} !== 3'b000) begin
                errors++;
                $display("FAIL rstmid_quiet%0d: busy/se/done=%b expected 000", c,
                         {if_a.busy, if_a.shift_enable, if_a.done});
            end
        end
        checks++;
        if (exp_a.size() != 0) begin
            errors++;
            $display("FAIL rstmid_strobes: %0d queued bits unsent, expected 0", exp_a.size());
        end
        if_a.data_in = w2;
        if_a.load_valid = 1'b1;
        for (int i = 3; i >= 0; i--) exp_a.push_back(w2[i]);
        tick();
        if_a.load_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if ({if_a.done, rx_a} !== {1'b1, w2}) begin
            errors++;
            $display("FAIL rstmid_fresh: done/q=%b expected %b", {if_a.done, rx_a}, {1'b1, w2});
        end
        tick();
        $display("test_reset_midframe done rx=%b", rx_a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        if_a.load_valid = 1'b0;
        if_b.load_valid = 1'b0;
        if_c.load_valid = 1'b0;
        if_a.data_in = '0;
        if_b.data_in = '0;
        if_c.data_in = '0;
        test_reset();
        test_basic();
        test_div3();
        test_width8();
        test_back_to_back();
        test_load_ignored();
        test_reset_midframe();
        repeat (3) tick();
        checks++;
        if ((exp_a.size() + exp_b.size() + exp_c.size()) != 0) begin
            errors++;
            $display("FAIL drain: %0d expected bits never strobed, expected 0",
                     exp_a.size() + exp_b.size() + exp_c.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
